// File: rtl/nibble_serial_pkg.sv
// nibble_serial_pkg: shared state encoding, digit constants and index-width helper.
package nibble_serial_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int NIBBLE_W = 4;
    localparam int BCD_LIMIT = 9;
    localparam int BCD_ADJ = 6;
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: 4-bit adder slice with carry-in; decimal-adjusts each digit when
// NIBBLE_SERIAL_BCD_EN is defined.
module nibble_add4
    import nibble_serial_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] raw;
`ifdef NIBBLE_SERIAL_BCD_EN
    logic adj;
    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        adj = raw > 5'(BCD_LIMIT);
        s   = adj ? raw[3:0] + 4'(BCD_ADJ) : raw[3:0];
        co  = adj;
    end
`else
    always_comb begin
        raw     = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        {co, s} = raw;
    end
`endif
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-nibble adder rippling the carry through a register, one
// nibble per clock. Define NIBBLE_SERIAL_BCD_EN for decimal (BCD) digits.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter  int NIBBLES = 2,
    localparam int W = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data_in1,
    input  logic [W-1:0] data_in2,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic         cout
);
    localparam int IW = idx_w(NIBBLES);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          carry_q, carry_d, cout_q, cout_d;
    logic [3:0]    sa, sb, s;
    logic          co;

    // Constant-index mux keeps every part-select static.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                sa = a_q[i*NIBBLE_W +: NIBBLE_W];
                sb = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_add4 u_add (.a(sa), .b(sb), .ci(carry_q), .s(s), .co(co));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = data_in1;
                b_d     = data_in2;
                carry_d = cin;
                sum_d   = '0;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++)
                    if (idx_q == IW'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = s;
                carry_d = co;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign data_out  = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks on NIBBLES=1/2/4 instances plus a binary random
// regression; BCD vectors replace binary ones when NIBBLE_SERIAL_BCD_EN is defined.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv = '0, ordy = '1, ci = '0;
    logic [15:0] a [3];
    logic [15:0] b [3];
    wire  [2:0]  ir, ov, co;
    logic [3:0]  d0;
    logic [7:0]  d1;
    logic [15:0] d2;
    logic [15:0] dout [3];
    int          nib [3] = '{1, 2, 4};
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        dout[0] = {12'b0, d0};
        dout[1] = {8'b0, d1};
        dout[2] = d2;
    end

    nibble_serial_adder #(.NIBBLES(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .data_in1(a[0][3:0]), .data_in2(b[0][3:0]), .cin(ci[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(d0), .cout(co[0]));
    nibble_serial_adder #(.NIBBLES(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .data_in1(a[1][7:0]), .data_in2(b[1][7:0]), .cin(ci[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(d1), .cout(co[1]));
    nibble_serial_adder #(.NIBBLES(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .data_in1(a[2]), .data_in2(b[2]), .cin(ci[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(d2), .cout(co[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after the accepting edge; counts edges until out_valid, then checks the sum.
    task automatic wait_res(input int u, input logic [16:0] exp, input string tag);
        int lat = 0;
        int w = 4 * nib[u];
        @(negedge clk);
        while (!ov[u] && lat < 30) begin
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(lat), 32'(nib[u]));
        check(tag, 32'(dout[u]) | (32'(co[u]) << w), 32'(exp));
    endtask

    task automatic xact(input int u, input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic [16:0] exp, input string tag, input logic hold);
        int t = 0;
        @(negedge clk);
        a[u] = x; b[u] = y; ci[u] = c; iv[u] = 1'b1; ordy[u] = !hold;
        while (!ir[u] && t < 30) begin
            t++;
            @(negedge clk);
        end
        if (!ir[u]) check({tag, "_accept"}, 32'(ir[u]), 32'd1);
        @(posedge clk);
        #1 iv[u] = 1'b0;
        wait_res(u, exp, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end
        #12;
        for (int i = 0; i < 3; i++)
            check($sformatf("rst%0d", i), {13'b0, ir[i], ov[i], co[i], dout[i]}, {13'b0, 3'b100, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
`ifdef NIBBLE_SERIAL_BCD_EN
        xact(1, 16'h45, 16'h38, 1'b0, 17'h083, "bcd_45_38", 1'b0);
        xact(1, 16'h99, 16'h01, 1'b0, 17'h100, "bcd_99_01", 1'b0);
        xact(0, 16'h9, 16'h9, 1'b1, 17'h19, "bcd_n1_9_9_c", 1'b0);
        xact(2, 16'h9999, 16'h0001, 1'b0, 17'h10000, "bcd_n4_wrap", 1'b0);
`else
        xact(0, 16'hF, 16'hF, 1'b0, 17'h1E, "n1_f_f", 1'b0);
        xact(1, 16'h0F, 16'h01, 1'b0, 17'h010, "n2_0f_01", 1'b0);
        xact(1, 16'hFF, 16'hFF, 1'b1, 17'h1FF, "n2_ff_ff_c", 1'b0);
        xact(2, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, "n4_wrap", 1'b0);
        xact(2, 16'h1234, 16'h8765, 1'b1, 17'h0999A, "n4_mix", 1'b0);
`endif
        // Backpressure: result frozen, new operands refused while the sink stalls.
        xact(1, 16'h12, 16'h34, 1'b0, 17'h046, "bp_first", 1'b1);
        a[1] = 16'h55; b[1] = 16'h11; ci[1] = 1'b0; iv[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {13'b0, ir[1], ov[1], co[1], dout[1]}, {13'b0, 3'b010, 16'h0046});
        end
        ordy[1] = 1'b1;
        @(negedge clk);
        check("bp_ready_back", {30'b0, ir[1], ov[1]}, 32'b10);
        @(posedge clk);
        #1 iv[1] = 1'b0;
        wait_res(1, 17'h066, "bp_second");
        // Asynchronous reset in the middle of a 4-nibble run.
        @(negedge clk);
        a[2] = 16'h1111; b[2] = 16'h2222; ci[2] = 1'b0; iv[2] = 1'b1;
        @(posedge clk);
        #1 iv[2] = 1'b0;
        @(posedge clk);
        #1 check("mid_run", {13'b0, ir[2], ov[2], co[2], dout[2]}, {13'b0, 3'b000, 16'h0003});
        rst_n = 1'b0;
        #1 check("async_rst", {13'b0, ir[2], ov[2], co[2], dout[2]}, {13'b0, 3'b100, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        xact(2, 16'h1234, 16'h4321, 1'b0, 17'h05555, "post_rst", 1'b0);
`ifndef NIBBLE_SERIAL_BCD_EN
        for (int i = 0; i < 1000; i++) begin
            int u = i % 3;
            logic [15:0] m = 16'((32'h1 << (4 * nib[u])) - 1);
            logic [15:0] x = 16'($urandom) & m;
            logic [15:0] y = 16'($urandom) & m;
            logic c = 1'($urandom);
            xact(u, x, y, c, 17'(x) + 17'(y) + 17'(c), "rand", 1'b0);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
